// File: rtl/alert_irq_ctrl.sv
// Turns alert rising edges into a level interrupt with an ack-started holdoff window.
// Latency: a rise sets pending on its edge; irq follows one edge later if enabled and idle.
module alert_irq_ctrl #(
    parameter int HOLDOFF_WIDTH = 16,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     alert,
    input  logic                     irq_en,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles,
    input  logic                     irq_ack,
    output logic                     irq,
    output logic                     pending,
    output logic [COUNT_WIDTH-1:0]   alert_count,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     alert_q;
    logic                     pending_q, pending_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
    logic                     rise;

    assign rise = alert & ~alert_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        hold_d    = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q && irq_en) begin
                    state_d   = ST_ASSERT;
                    pending_d = 1'b0;
                end
            end
            ST_ASSERT: begin
                if (irq_ack) begin
                    if (holdoff_cycles == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hold_d  = holdoff_cycles;
                    end
                end else if (!irq_en) begin
                    // Interrupt withdrawn before service: re-arm so the event is not lost.
                    state_d   = ST_IDLE;
                    pending_d = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                hold_d = hold_q - HOLDOFF_WIDTH'(1);
                if (hold_q == HOLDOFF_WIDTH'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new edge always wins over any clear on the same cycle.
        if (rise) begin
            pending_d = 1'b1;
            if (!(&count_q)) begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            alert_q   <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            alert_q   <= alert;
            pending_q <= pending_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
        end
    end

    assign irq         = (state_q == ST_ASSERT);
    assign busy        = (state_q != ST_IDLE);
    assign pending     = pending_q;
    assign alert_count = count_q;

endmodule

// File: tb/tb_alert_irq_ctrl.sv
// Directed bench for alert_irq_ctrl with a cycle-level reference model and literal spot checks.
module tb_alert_irq_ctrl;

    localparam int HW   = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          aclk;
    logic          aresetn;
    logic          alert;
    logic          irq_en;
    logic [HW-1:0] holdoff_cycles;
    logic          irq_ack;
    logic          irq;
    logic          pending;
    logic [CW-1:0] alert_count;
    logic          busy;

    int total = 0;
    int bad   = 0;
    logic run = 1'b0;

    alert_irq_ctrl #(.HOLDOFF_WIDTH(HW), .COUNT_WIDTH(CW)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .alert          (alert),
        .irq_en         (irq_en),
        .holdoff_cycles (holdoff_cycles),
        .irq_ack        (irq_ack),
        .irq            (irq),
        .pending        (pending),
        .alert_count    (alert_count),
        .busy           (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Model: irq is "interrupt being shown", m_hold is the number of quiet cycles still owed.
    logic m_irq, m_busy, m_pend, m_prev, m_rise;
    int   m_cnt, m_hold;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_irq = 0; m_busy = 0; m_pend = 0; m_prev = 0; m_cnt = 0; m_hold = 0;
        end else begin
            m_rise = alert && !m_prev;
            m_prev = alert;
            if (m_irq) begin
                if (irq_ack) begin
                    m_irq  = 0;
                    m_hold = int'(holdoff_cycles);
                    m_busy = (m_hold != 0);
                end else if (!irq_en) begin
                    m_irq = 0; m_busy = 0; m_pend = 1;
                end
            end else if (m_hold > 0) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) m_busy = 0;
            end else if (m_pend && irq_en) begin
                m_irq = 1; m_busy = 1; m_pend = 0;
            end
            if (m_rise) begin
                m_pend = 1;
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        if (run && aresetn) begin
            check("model_irq",     int'(irq),         int'(m_irq));
            check("model_busy",    int'(busy),        int'(m_busy));
            check("model_pending", int'(pending),     int'(m_pend));
            check("model_count",   int'(alert_count), m_cnt);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_irq();
        int n = 0;
        while (!irq && n < 20) begin
            tick();
            n++;
        end
        check("wait_irq", int'(irq), 1);
    endtask

    initial begin
        aresetn = 0; alert = 0; irq_en = 0; holdoff_cycles = '0; irq_ack = 0;
        #3;
        check("rst_irq", int'(irq), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(alert_count), 0);
        tick();
        aresetn = 1;
        run = 1;
        tick();

        // Basic edge -> pending -> irq -> ack with zero holdoff.
        irq_en = 1; alert = 1;
        tick();
        check("s1_pending", int'(pending), 1);
        check("s1_irq_early", int'(irq), 0);
        check("s1_count", int'(alert_count), 1);
        tick();
        check("s1_irq", int'(irq), 1);
        check("s1_pending_clr", int'(pending), 0);
        alert = 0;
        tick(); tick();
        irq_ack = 1;
        tick();
        irq_ack = 0;
        check("s1_ack_irq", int'(irq), 0);
        check("s1_ack_busy", int'(busy), 0);

        // Holdoff of 5 with a rise during the window; ack/en/holdoff disturbances ignored.
        holdoff_cycles = 5;
        alert = 1; tick(); alert = 0; tick();
        check("s2_irq", int'(irq), 1);
        irq_ack = 1; tick(); irq_ack = 0;
        alert = 1; tick(); alert = 0;
        check("s2_hold_pending", int'(pending), 1);
        check("s2_hold_irq", int'(irq), 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) irq_ack = 1;
            if (i == 1) begin irq_ack = 0; irq_en = 0; holdoff_cycles = 2; end
            if (i == 2) begin irq_en = 1; holdoff_cycles = 5; end
            tick();
            check("s2_hold_busy", int'(busy), 1);
            check("s2_hold_irq_loop", int'(irq), 0);
        end
        tick();
        check("s2_idle_busy", int'(busy), 0);
        check("s2_idle_pending", int'(pending), 1);
        tick();
        check("s2_reirq", int'(irq), 1);
        check("s2_count", int'(alert_count), 3);
        holdoff_cycles = 0;
        irq_ack = 1; tick(); irq_ack = 0;
        check("s2_done", int'(busy), 0);

        // Disabled: three pulses coalesce, then one irq on enable.
        irq_en = 0;
        for (int i = 0; i < 3; i++) begin
            alert = 1; tick(); alert = 0; tick();
        end
        check("s3_irq", int'(irq), 0);
        check("s3_pending", int'(pending), 1);
        check("s3_count", int'(alert_count), 6);
        irq_en = 1;
        tick();
        check("s3_irq_on", int'(irq), 1);
        check("s3_pending_clr", int'(pending), 0);
        irq_ack = 1; tick(); irq_ack = 0;

        // Enable dropped while asserted, no ack.
        alert = 1; tick(); alert = 0; tick();
        check("s4_irq", int'(irq), 1);
        irq_en = 0;
        tick();
        check("s4_drop_irq", int'(irq), 0);
        check("s4_drop_busy", int'(busy), 0);
        check("s4_drop_pending", int'(pending), 1);
        irq_en = 1;
        tick();
        check("s4_restore_irq", int'(irq), 1);
        irq_ack = 1; tick(); irq_ack = 0;

        // Saturation, then asynchronous reset in a long holdoff.
        for (int i = 0; i < 20; i++) begin
            alert = 1; tick(); alert = 0; tick();
        end
        check("s5_sat", int'(alert_count), 15);
        holdoff_cycles = 100;
        wait_irq();
        irq_ack = 1; tick(); irq_ack = 0;
        check("s5_hold_busy", int'(busy), 1);
        tick(); tick(); tick();
        #2;
        aresetn = 0;
        #1;
        check("s5_arst_irq", int'(irq), 0);
        check("s5_arst_busy", int'(busy), 0);
        check("s5_arst_pending", int'(pending), 0);
        check("s5_arst_count", int'(alert_count), 0);

        // Alert held high through reset release counts as a fresh rise.
        alert = 1; irq_en = 1; holdoff_cycles = 0;
        tick();
        aresetn = 1;
        tick();
        check("s6_pending", int'(pending), 1);
        check("s6_irq_early", int'(irq), 0);
        check("s6_count", int'(alert_count), 1);
        tick();
        check("s6_irq", int'(irq), 1);
        check("s6_pending_clr", int'(pending), 0);

        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alert_irq_ctrl.md
ALERT_IRQ_CTRL -- requirements
Module: alert_irq_ctrl

Interface
REQ-001 HOLDOFF_WIDTH, default 16, width of the holdoff count input.
REQ-002 COUNT_WIDTH, default 16, width of the alert event counter.
REQ-003 aclk  input  1  single clock; all state updates on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous and active-low.
REQ-005 alert  input  1  level "status changed since last read" from the upstream status-alert register; synchronous to aclk.
REQ-006 irq_en  input  1  interrupt enable; level.
REQ-007 holdoff_cycles  input  HOLDOFF_WIDTH  minimum idle cycles enforced after each acknowledge; sampled on acknowledge.
REQ-008 irq_ack  input  1  single-cycle acknowledge from software/PS glue.
REQ-009 irq  output  1  registered interrupt request, level-high.
REQ-010 pending  output  1  registered flag: an alert edge is waiting to be signalled.
REQ-011 alert_count  output  COUNT_WIDTH  registered count of alert rising edges, saturating.
REQ-012 busy  output  1  registered; high when state is ASSERT or HOLDOFF.

Function
REQ-013 SHALL register alert into alert_q each cycle; rise = alert & ~alert_q.
REQ-014 SHALL implement three states: IDLE, ASSERT, HOLDOFF; irq = (state == ASSERT), busy = (state != IDLE), both from registered state.
REQ-015 On rise, pending SHALL be 1 after that edge, in any state.
REQ-016 IDLE: if pending & irq_en, next state ASSERT and pending cleared on the same edge; otherwise remain IDLE.
REQ-017 Latency: alert sampled high (alert_q low) at edge k -> pending = 1 after k -> irq = 1 after edge k+1.
REQ-018 A rise on the same edge that clears pending (IDLE->ASSERT) SHALL leave pending = 1 (set wins over clear).
REQ-019 ASSERT: irq_ack -> if holdoff_cycles == 0 next state IDLE, else HOLDOFF with counter loaded with holdoff_cycles.
REQ-020 ASSERT: irq_en low and no irq_ack -> next state IDLE and pending set to 1 (event not lost); irq_ack takes priority over irq_en low.
REQ-021 HOLDOFF: counter decrements by 1 per cycle; when counter == 1 next state IDLE; irq stays 0 for exactly holdoff_cycles cycles after the ack edge.
REQ-022 irq_ack outside ASSERT SHALL be ignored (no state, pending or counter change).
REQ-023 Rises during ASSERT or HOLDOFF SHALL coalesce into the single pending bit; each still increments alert_count.
REQ-024 alert_count SHALL increment by 1 per rise and saturate at 2^COUNT_WIDTH-1 (no wrap).
REQ-025 irq_en changes during HOLDOFF SHALL not affect the countdown.
REQ-026 holdoff_cycles changes during HOLDOFF SHALL not affect the running countdown.

Reset
REQ-027 aresetn low SHALL asynchronously force state IDLE, irq 0, busy 0, pending 0, alert_count 0, alert_q 0, holdoff counter 0, at any point including mid-ASSERT/HOLDOFF.
REQ-028 alert held high through reset release SHALL register as a rise on the first active edge (alert_q resets to 0), so stale status is always signalled.
REQ-029 Deassertion of aresetn is synchronised externally to aclk; block requires no internal reset synchroniser.

Verification
REQ-030 irq_en=1, holdoff=0, alert 0->1 at edge 10 -> pending=1 after edge 10, irq=1 after edge 11, alert_count=1; irq_ack at edge 15 -> irq=0, state IDLE after edge 15.
REQ-031 holdoff=5, alert rises, ack at edge 20, second alert rise at edge 21 -> irq=0 for edges 21..25, pending=1 throughout, irq=1 again after edge 26, alert_count=2.
REQ-032 irq_en=0, three alert pulses (0-1-0) -> irq stays 0, pending=1, alert_count=3; set irq_en=1 -> single irq assertion next cycle, pending=0.
REQ-033 In ASSERT drop irq_en for one cycle without ack -> irq=0, state IDLE, pending=1; restore irq_en -> irq=1 one cycle later.
REQ-034 COUNT_WIDTH=4, 20 alert rises -> alert_count=15, no wrap; assert aresetn=0 mid-HOLDOFF (holdoff=100) -> all outputs 0 immediately, without waiting for a clock edge.
REQ-035 alert held high across reset release with irq_en=1 -> pending=1 after first edge, irq=1 after second edge, alert_count=1.
